// File: rtl/agc_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : agc_seq_ctrl_pkg
// Brief  : Shared opcodes, register map, state encoding and CCS helper.
// Rev    : 1.0
// ============================================================================
package agc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPRD   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] OP_TC   = 3'd0;
  localparam logic [2:0] OP_CCS  = 3'd1;
  localparam logic [2:0] OP_NOP  = 3'd2;
  localparam logic [2:0] OP_XCH  = 3'd3;
  localparam logic [2:0] OP_CS   = 3'd4;
  localparam logic [2:0] OP_TS   = 3'd5;
  localparam logic [2:0] OP_AD   = 3'd6;
  localparam logic [2:0] OP_MASK = 3'd7;

  localparam int unsigned REG_A    = 0;
  localparam int unsigned REG_Q    = 1;
  localparam int unsigned REG_Z    = 2;
  localparam int unsigned EXTEND_K = 6;

  // Skip distance for CCS: +nonzero 0, +0 1, -nonzero 2, -0 3.
  function automatic logic [1:0] ccs_skip(input logic is_neg, input logic is_zero);
    return {is_neg, is_zero};
  endfunction

endpackage
`default_nettype wire

// File: rtl/agc_seq_ctrl_oc_adder.sv
`default_nettype none
// ============================================================================
// Module : oc_adder
// Brief  : Combinational ones'-complement adder with end-around carry.
// Rev    : 1.0
// ============================================================================
module oc_adder #(
  parameter int unsigned DATA_W = 15
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  // A carry-out leaves the low bits at most all-ones minus one, so one fold suffices.
  assign sum = raw[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, raw[DATA_W]};

endmodule
`default_nettype wire

// File: rtl/agc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : agc_seq_ctrl
// Brief  : Five-state fetch/decode/operand/execute/write-back AGC control unit.
// Rev    : 1.0
// ============================================================================
module agc_seq_ctrl
  import agc_seq_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W   = 15,
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_done,
  output logic              extracode,
  output logic [DATA_W-1:0] a_o,
  output logic [ADDR_W-1:0] z_o
);

  localparam logic [DATA_W-1:0] PZERO  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] MZERO  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] OC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, q_q, q_d, ir_q, ir_d, res_q, res_d;
  logic [ADDR_W-1:0]   z_q, z_d;
  logic                ext_q, ext_d;
  logic                mem_re_q, mem_re_d, mem_we_q, mem_we_d, done_q, done_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [2:0]          op;
  logic [ADDR_W-1:0]   k;
  logic [DATA_W-1:0]   fetch_word, opnd_word, add_x, add_y, add_sum;
  logic                k_int, is_extend, m_sign, m_zero;
  logic                do_tc, do_ccs, do_xch, do_cs, do_ts, do_ad, do_su, do_mask;

  function automatic logic is_reg(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_W'(REG_Z);
  endfunction

  assign op = ir_q[DATA_W-1 -: 3];
  assign k  = ir_q[ADDR_W-1:0];

  assign k_int     = is_reg(k);
  assign is_extend = (op == OP_TC) && (k == ADDR_W'(EXTEND_K));
  assign do_tc     = (op == OP_TC) && !is_extend;
  assign do_ccs    = (op == OP_CCS)  && !ext_q;
  assign do_xch    = (op == OP_XCH)  && !ext_q;
  assign do_cs     = (op == OP_CS)   && !ext_q;
  assign do_ts     = (op == OP_TS)   && !ext_q;
  assign do_ad     = (op == OP_AD)   && !ext_q;
  assign do_su     = (op == OP_AD)   &&  ext_q;
  assign do_mask   = (op == OP_MASK) && !ext_q;

  // Addresses 0..2 alias the central registers instead of memory.
  always_comb begin
    fetch_word = mem_rdata;
    if (z_q == ADDR_W'(REG_A))      fetch_word = a_q;
    else if (z_q == ADDR_W'(REG_Q)) fetch_word = q_q;
    else if (z_q == ADDR_W'(REG_Z)) fetch_word = {{(DATA_W-ADDR_W){1'b0}}, z_q};

    opnd_word = mem_rdata;
    if (k == ADDR_W'(REG_A))        opnd_word = a_q;
    else if (k == ADDR_W'(REG_Q))   opnd_word = q_q;
    else if (k == ADDR_W'(REG_Z))   opnd_word = {{(DATA_W-ADDR_W){1'b0}}, z_q};
  end

  assign m_sign = opnd_word[DATA_W-1];
  assign m_zero = (opnd_word == PZERO) || (opnd_word == MZERO);

  always_comb begin
    add_x = a_q;
    add_y = opnd_word;
    if (do_ccs) begin
      add_x = m_sign ? ~opnd_word : opnd_word;
      add_y = ~OC_ONE;
    end else if (do_su) begin
      add_y = ~opnd_word;
    end
  end

  oc_adder #(.DATA_W(DATA_W)) u_oc_adder (
    .a   (add_x),
    .b   (add_y),
    .sum (add_sum)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    z_d         = z_q;
    ext_d       = ext_q;
    ir_d        = ir_q;
    res_d       = res_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          mem_addr_d = z_q;
          mem_re_d   = !is_reg(z_q);
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        state_d    = S_OPRD;
        ir_d       = fetch_word;
        z_d        = z_q + ADDR_W'(1);
        mem_addr_d = fetch_word[ADDR_W-1:0];
        mem_re_d   = (fetch_word[DATA_W-1 -: 3] != OP_TC) && !is_reg(fetch_word[ADDR_W-1:0]);
      end
      S_OPRD: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WB;
        done_d  = 1'b1;
        res_d   = a_q;
        if (do_ccs) begin
          res_d = m_zero ? PZERO : add_sum;
          z_d   = z_q + ADDR_W'(ccs_skip(m_sign, m_zero));
        end else if (do_ad || do_su) begin
          res_d = add_sum;
        end else if (do_xch) begin
          res_d = opnd_word;
        end else if (do_cs) begin
          res_d = ~opnd_word;
        end else if (do_mask) begin
          res_d = a_q & opnd_word;
        end
        if ((do_xch || do_ts) && !k_int) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = k;
          mem_wdata_d = a_q;
        end
      end
      S_WB: begin
        a_d   = res_q;
        ext_d = is_extend;
        if (do_tc) begin
          q_d = {{(DATA_W-ADDR_W){1'b0}}, z_q};
          z_d = k;
        end
        // Internal stores land last so TS/XCH to Z override the incremented PC.
        if ((do_xch || do_ts) && k_int) begin
          if (k == ADDR_W'(REG_A))      a_d = a_q;
          else if (k == ADDR_W'(REG_Q)) q_d = a_q;
          else                          z_d = a_q[ADDR_W-1:0];
        end
        if (run) begin
          state_d    = S_FETCH;
          mem_addr_d = z_d;
          mem_re_d   = !is_reg(z_d);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      z_q         <= RESET_PC;
      ext_q       <= 1'b0;
      ir_q        <= '0;
      res_q       <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      z_q         <= z_d;
      ext_q       <= ext_d;
      ir_q        <= ir_d;
      res_q       <= res_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign instr_done = done_q;
  assign extracode  = ext_q;
  assign a_o        = a_q;
  assign z_o        = z_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_agc_seq_ctrl
// Brief  : Directed program with queued expectations for agc_seq_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_agc_seq_ctrl;

  localparam int DW = 15;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          mem_re, mem_we, instr_done, extracode;
  logic [AW-1:0] mem_addr, z_o;
  logic [DW-1:0] mem_wdata, mem_rdata, a_o;

  bit            alt_prog = 1'b0;
  logic [DW-1:0] wmem [0:4095];
  bit            written [0:4095];

  typedef struct packed {logic [DW-1:0] a; logic [AW-1:0] z; logic ext;} st_t;
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;

  st_t           exp_st[$];
  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];

  int n_pass  = 0;
  int n_total = 0;

  agc_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .instr_done (instr_done),
    .extracode  (extracode),
    .a_o        (a_o),
    .z_o        (z_o)
  );

  always #5 clk = ~clk;

  // Program/data image; alt selects the image used for the reset-abort test.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] addr, input bit alt);
    case (addr)
      12'h800: rom = alt ? 15'h3041 : 15'h4011;
      12'h801: rom = 15'h6010;
      12'h802: rom = 15'h0900;
      12'h010: rom = 15'h7FFE;
      12'h011: rom = 15'h7FFC;
      12'h900: rom = 15'h1020;
      12'h903: rom = 15'h1022;
      12'h905: rom = 15'h1023;
      12'h909: rom = 15'h1024;
      12'h90A: rom = 15'h4025;
      12'h90B: rom = 15'h0006;
      12'h90C: rom = 15'h6026;
      12'h90D: rom = 15'h0006;
      12'h90E: rom = 15'h7027;
      12'h90F: rom = 15'h7027;
      12'h910: rom = 15'h0123;
      12'h020: rom = 15'h7FFA;
      12'h022: rom = 15'h0000;
      12'h023: rom = 15'h7FFF;
      12'h024: rom = 15'h0007;
      12'h025: rom = 15'h7FFA;
      12'h026: rom = 15'h0002;
      12'h027: rom = 15'h0006;
      12'h123: rom = 15'h3001;
      12'h124: rom = 15'h4028;
      12'h125: rom = 15'h3040;
      12'h126: rom = 15'h4029;
      12'h127: rom = 15'h5002;
      12'h028: rom = 15'h6EEE;
      12'h029: rom = 15'h7BA9;
      12'h040: rom = 15'h2222;
      12'h041: rom = 15'h5555;
      12'h456: rom = 15'h3000;
      12'h457: rom = 15'h0FFF;
      12'hFFF: rom = 15'h602B;
      12'h02B: rom = 15'h0001;
      default: rom = 15'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= written[mem_addr] ? wmem[mem_addr] : rom(mem_addr, alt_prog);
    if (mem_we) begin
      wmem[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic issue(input logic [AW-1:0] pc, input bit rd_op, input logic [AW-1:0] op_addr,
                       input logic [DW-1:0] a, input logic [AW-1:0] z, input bit ext);
    st_t s;
    exp_rd.push_back(pc);
    if (rd_op) exp_rd.push_back(op_addr);
    s.a = a; s.z = z; s.ext = ext;
    exp_st.push_back(s);
  endtask

  // Called at a negedge; holds run until the last instruction has fetched.
  task automatic run_instrs(input int n);
    int cyc;
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (i == n - 1) run = 1'b0;
      end while (!instr_done && cyc < 12);
      chk("instr_latency", 32'(cyc), 32'd5);
    end
  endtask

  // Architectural state is compared on the cycle after WB, once it has committed.
  initial begin
    bit  pend = 1'b0;
    st_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_st.size() == 0) chk("unexpected_done", 32'(exp_st.size()), 32'd1);
        else begin
          e = exp_st.pop_front();
          chk("a_after_wb", 32'(a_o), 32'(e.a));
          chk("z_after_wb", 32'(z_o), 32'(e.z));
          chk("extracode_after_wb", 32'(extracode), 32'(e.ext));
        end
      end
      pend = instr_done;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_re) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
        else chk("read_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
      end
    end
  end

  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          w = exp_wr.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w.addr));
          chk("write_data", 32'(mem_wdata), 32'(w.data));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    wr_t w;
    repeat (2) @(negedge clk);
    chk("reset_a", 32'(a_o), 32'h0);
    chk("reset_z", 32'(z_o), 32'h800);
    chk("reset_ext", 32'(extracode), 32'h0);
    chk("reset_strobes", 32'({mem_re, mem_we, instr_done}), 32'h0);
    chk("reset_addr_wdata", 32'({mem_addr, mem_wdata}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(12'h800, 1, 12'h011, 15'h0003, 12'h801, 0);   // CS
    issue(12'h801, 1, 12'h010, 15'h0002, 12'h802, 0);   // AD
    run_instrs(2);

    issue(12'h802, 0, 12'h000, 15'h0002, 12'h900, 0);   // TC 0x900
    issue(12'h900, 1, 12'h020, 15'h0004, 12'h903, 0);   // CCS -5
    issue(12'h903, 1, 12'h022, 15'h0000, 12'h905, 0);   // CCS +0
    issue(12'h905, 1, 12'h023, 15'h0000, 12'h909, 0);   // CCS -0
    issue(12'h909, 1, 12'h024, 15'h0006, 12'h90A, 0);   // CCS +7
    issue(12'h90A, 1, 12'h025, 15'h0005, 12'h90B, 0);   // CS
    run_instrs(6);

    issue(12'h90B, 0, 12'h000, 15'h0005, 12'h90C, 1);   // EXTEND
    issue(12'h90C, 1, 12'h026, 15'h0003, 12'h90D, 0);   // SU
    run_instrs(2);

    issue(12'h90D, 0, 12'h000, 15'h0003, 12'h90E, 1);   // EXTEND
    issue(12'h90E, 1, 12'h027, 15'h0003, 12'h90F, 0);   // reserved MASK
    issue(12'h90F, 1, 12'h027, 15'h0002, 12'h910, 0);   // MASK
    issue(12'h910, 0, 12'h000, 15'h0002, 12'h123, 0);   // TC 0x123
    issue(12'h123, 0, 12'h000, 15'h0911, 12'h124, 0);   // XCH Q
    issue(12'h124, 1, 12'h028, 15'h1111, 12'h125, 0);   // CS
    issue(12'h125, 1, 12'h040, 15'h2222, 12'h126, 0);   // XCH 0x040
    w.addr = 12'h040; w.data = 15'h1111;
    exp_wr.push_back(w);
    issue(12'h126, 1, 12'h029, 15'h0456, 12'h127, 0);   // CS
    issue(12'h127, 0, 12'h000, 15'h0456, 12'h456, 0);   // TS Z
    issue(12'h456, 0, 12'h000, 15'h0456, 12'h457, 0);   // XCH A
    issue(12'h457, 0, 12'h000, 15'h0456, 12'hFFF, 0);   // TC 0xFFF
    issue(12'hFFF, 1, 12'h02B, 15'h0457, 12'h000, 0);   // AD, Z wraps
    run_instrs(12);
    @(negedge clk);

    // Reset during the write-back of an external XCH.
    alt_prog = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset2_z", 32'(z_o), 32'h800);
    chk("reset2_a", 32'(a_o), 32'h0);
    exp_rd.push_back(12'h800);
    exp_rd.push_back(12'h041);
    rst_n = 1'b1;
    run = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!instr_done && cyc < 10);
    chk("abort_wb_latency", 32'(cyc), 32'd5);
    chk("abort_we_in_wb", 32'(mem_we), 32'h1);
    chk("abort_waddr", 32'(mem_addr), 32'h041);
    chk("abort_wdata", 32'(mem_wdata), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort_we_dropped", 32'({mem_re, mem_we, instr_done}), 32'h0);
    chk("abort_addr_wdata", 32'({mem_addr, mem_wdata}), 32'h0);
    chk("abort_a", 32'(a_o), 32'h0);
    chk("abort_z", 32'(z_o), 32'h800);
    chk("abort_ext", 32'(extracode), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_write", 32'(written[12'h041]), 32'h0);

    rst_n = 1'b1;
    issue(12'h800, 1, 12'h041, 15'h5555, 12'h801, 0);
    w.addr = 12'h041; w.data = 15'h0000;
    exp_wr.push_back(w);
    run_instrs(1);
    @(negedge clk);
    @(negedge clk);
    chk("xch_mem_040", 32'(wmem[12'h040]), 32'h1111);
    chk("pending_states", 32'(exp_st.size()), 32'h0);
    chk("pending_reads", 32'(exp_rd.size()), 32'h0);
    chk("pending_writes", 32'(exp_wr.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
